// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Owns the program counter, drives the
//               instruction-memory address every cycle, pairs each returning
//               word (one-cycle registered read) with its PC and hands it to
//               decode through a valid/ready handshake backed by a 2-entry
//               buffer. A redirect flushes all fetched-but-undelivered work.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               pc_out                - address to instruction memory
//               instr_in              - memory read data (one cycle later)
//               redirect_valid/target - load new PC (low 2 bits ignored)
//               fetch_ready           - decode can accept
//               fetch_valid/pc/instr  - buffer head towards decode
//               perf_fetched/stalls   - counters, only with FETCH_PERF_EN
// Config      : define FETCH_PERF_EN to add the performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int                width    = 32,
    parameter logic [width-1:0]  RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic [width-1:0] pc_out,
    input  logic [width-1:0] instr_in,
    input  logic             redirect_valid,
    input  logic [width-1:0] redirect_target,
    input  logic             fetch_ready,
    output logic             fetch_valid,
    output logic [width-1:0] fetch_pc,
    output logic [width-1:0] fetch_instr
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]      perf_fetched,
    output logic [31:0]      perf_stalls
`endif
);

    localparam logic [width-1:0] c_PC_STEP = width'(4);

    logic [width-1:0] r_pc;
    logic             r_inf;
    logic [width-1:0] r_inf_pc;
    logic [width-1:0] r_fifo_pc    [2];
    logic [width-1:0] r_fifo_instr [2];
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    logic             w_pop;
    logic             w_push;
    logic             w_issue;
    logic [2:0]       w_occ;
    logic             w_wr_idx;
    logic [1:0]       w_unused_tgt_lsb;

    assign w_unused_tgt_lsb = redirect_target[1:0];

    assign pc_out      = r_pc;
    assign fetch_valid = (r_count != 2'd0) && !redirect_valid && !rst;
    assign fetch_pc    = r_fifo_pc[r_rd_ptr];
    assign fetch_instr = r_fifo_instr[r_rd_ptr];

    assign w_pop  = fetch_valid && fetch_ready;
    assign w_push = r_inf;

    // Words already buffered plus the one in flight; a new fetch is only
    // started when, after this cycle's pop, at most one slot is committed.
    assign w_occ   = {1'b0, r_count} + {2'b00, r_inf};
    assign w_issue = !rst && !redirect_valid && (w_occ <= (3'd1 + {2'b00, w_pop}));

    // Tail slot = head + count (mod 2). With count==2 this aliases the head,
    // which is only legal because a push at count 2 always coincides with a pop.
    assign w_wr_idx = r_rd_ptr ^ r_count[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc            <= RESET_PC;
            r_inf           <= 1'b0;
            r_inf_pc        <= '0;
            r_rd_ptr        <= 1'b0;
            r_count         <= 2'd0;
            r_fifo_pc[0]    <= '0;
            r_fifo_pc[1]    <= '0;
            r_fifo_instr[0] <= '0;
            r_fifo_instr[1] <= '0;
        end else if (redirect_valid) begin
            // Flush: the word returning next cycle is simply never pushed.
            r_pc    <= {redirect_target[width-1:2], 2'b00};
            r_inf   <= 1'b0;
            r_count <= 2'd0;
        end else begin
            r_inf <= w_issue;
            if (w_issue) begin
                r_inf_pc <= r_pc;
                r_pc     <= r_pc + c_PC_STEP;
            end
            if (w_push) begin
                r_fifo_pc[w_wr_idx]    <= r_inf_pc;
                r_fifo_instr[w_wr_idx] <= instr_in;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

`ifdef FETCH_PERF_EN
    // Counters survive redirects; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stalls  <= '0;
        end else begin
            if (w_pop) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (fetch_valid && !fetch_ready) begin
                perf_stalls <= perf_stalls + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. A behavioural model
//               predicts the delivered stream (consecutive PCs from the last
//               reset/redirect target, each with its memory word) and when
//               fetch_valid must be high; a monitor compares every handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_out;
    logic [31:0] instr_in;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stalls;
`endif

    fetch_unit #(.width(32), .RESET_PC(32'h0)) dut (
        .clk             (clk),
        .rst             (rst),
        .pc_out          (pc_out),
        .instr_in        (instr_in),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .fetch_ready     (fetch_ready),
        .fetch_valid     (fetch_valid),
        .fetch_pc        (fetch_pc),
        .fetch_instr     (fetch_instr)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched    (perf_fetched),
        .perf_stalls     (perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory: 256 words, registered read of the presented address.
    logic [31:0] mem [256];
    always @(posedge clk) instr_in <= mem[pc_out[9:2]];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // After a flush the stream restarts at the new PC and proceeds in +4 steps.
    task automatic flush_model(input logic [31:0] start);
        logic [31:0] p;
        exp_t e;
        exp_q.delete();
        p = start;
        for (int i = 0; i < 200; i++) begin
            e.pc    = p;
            e.instr = mem[p[9:2]];
            exp_q.push_back(e);
            p = p + 32'd4;
        end
    endtask

    task automatic cyc(input logic r, input logic rv, input logic [31:0] tgt, input logic rdy);
        @(posedge clk);
        #1;
        rst             = r;
        redirect_valid  = rv;
        redirect_target = tgt;
        fetch_ready     = rdy;
        if (r)       flush_model(32'h0);
        else if (rv) flush_model({tgt[31:2], 2'b00});
    endtask

    // ---------------- monitor / scoreboard ----------------
    int   since   = 0;
    logic started = 1'b0;
`ifdef FETCH_PERF_EN
    logic [31:0] m_fetched = 0;
    logic [31:0] m_stalls  = 0;
`endif

    always @(negedge clk) begin
        logic [31:0] ahead;
        exp_t e;
        if (rst || redirect_valid) begin
            since = 0;
            if (started) check("valid_in_flush", {31'b0, fetch_valid}, 32'd0);
        end else begin
            since++;
            if (started) check("valid_timing", {31'b0, fetch_valid}, {31'b0, (since >= 3)});
        end
`ifdef FETCH_PERF_EN
        if (started) begin
            check("perf_fetched", perf_fetched, m_fetched);
            check("perf_stalls",  perf_stalls,  m_stalls);
        end
        if (rst) begin
            m_fetched = 0;
            m_stalls  = 0;
        end else begin
            if (fetch_valid && fetch_ready)  m_fetched = m_fetched + 1;
            if (fetch_valid && !fetch_ready) m_stalls  = m_stalls + 1;
        end
`endif
        if (started && fetch_valid) begin
            if (exp_q.size() == 0) begin
                check("queue_underrun", 32'd1, 32'd0);
            end else begin
                // Fetch never runs more than two words ahead of the head.
                ahead = pc_out - exp_q[0].pc;
                check("pc_out_ahead", {31'b0, (ahead == 32'd4 || ahead == 32'd8)}, 32'd1);
                if (fetch_ready) begin
                    e = exp_q.pop_front();
                    check("fetch_pc",    fetch_pc,    e.pc);
                    check("fetch_instr", fetch_instr, e.instr);
                end else begin
                    check("head_pc_hold", fetch_pc, exp_q[0].pc);
                end
            end
        end
        if (rst) started = 1'b1;
    end

    // ---------------- stimulus ----------------
    initial begin
        int seg;
        int r;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h00000033;
        mem[1] = 32'h00638433;
        mem[2] = 32'h406384b3;
        mem[7] = 32'h00735733;
        mem[8] = 32'h407657b3;

        rst = 1'b1; redirect_valid = 1'b0; redirect_target = '0; fetch_ready = 1'b1;
        flush_model(32'h0);

        // Reset state after the first reset edge.
        @(negedge clk);
        check("rst_pc_out",      pc_out,      32'h0);
        check("rst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
        check("rst_fetch_pc",    fetch_pc,    32'h0);
        check("rst_fetch_instr", fetch_instr, 32'h0);
`ifdef FETCH_PERF_EN
        check("rst_perf_fetched", perf_fetched, 32'h0);
        check("rst_perf_stalls",  perf_stalls,  32'h0);
`endif
        cyc(1, 0, 0, 1);

        // Straight-line fetch, then a 3-cycle stall while the head is pc 0x4.
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);

        // Redirect to 0x20.
        cyc(0, 1, 32'h20, 1);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1);

        // Fill the buffer, then redirect to an unaligned target.
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
        cyc(0, 1, 32'h1E, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1);

        // One-cycle reset mid-stream.
        cyc(1, 0, 0, 1);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1);

        // Randomized traffic: ready jitter, redirects, occasional reset.
        seg = 0;
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 99);
            seg++;
            if (r < 2) begin
                cyc(1, 0, 0, 1'($urandom % 2));
                seg = 0;
            end else if (r < 8 || seg > 100) begin
                cyc(0, 1, $urandom, 1'($urandom % 2));
                seg = 0;
            end else begin
                cyc(0, 0, $urandom, 1'(($urandom % 4) != 0));
            end
        end
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);

        @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
